dcache_refill_ctrl: RTL
=======================

DCACHE_REFILL_CTRL -- requirements
Module: dcache_refill_ctrl

Interface
REQ-001 The block SHALL have the following ports; the clock is rising-edge, and reset is asynchronous and active-low.
- clk  input  1  system clock.
- RESET_N  input  1  asynchronous, active-low reset.
- req_rd  input  1  MEM-stage load valid (ex_mem read enable).
- req_wr  input  1  MEM-stage store valid (ex_mem write enable).
- req_addr  input  32  MEM-stage byte address.
- miss  input  1  data-cache lookup missed for req_addr.
- dirty  input  1  victim line is dirty.
- victim_addr  input  32  byte address of the victim line.
- victim_line  input  128  victim data; word0 in [127:96], word3 in [31:0].
- mem_dout  input  32  memory port-2 read data, one-cycle synchronous latency.
- mem_addr  output  32  memory port-2 address.
- mem_rden  output  1  memory port-2 read enable.
- mem_we  output  1  memory port-2 write enable.
- mem_din  output  32  memory port-2 write data.
- mem_size  output  2  constant 2'b10 (word).
- mem_sign  output  1  constant 0.
- refill_line  output  128  assembled line; word0 in [127:96].
- refill_valid  output  1  one-cycle strobe: the cache writes refill_line.
- stall  output  1  freezes PC, IF/DEC, DEC/EX, EX/MEM and MEM/WB.

Function
REQ-002 The FSM SHALL have exactly these states: IDLE, WB, RD, FILL.
REQ-003 In IDLE, when miss is 1 and (req_rd or req_wr) is 1, the block SHALL latch line base {req_addr[31:4],4'h0} and victim base {victim_addr[31:4],4'h0}.
REQ-004 From IDLE under the REQ-003 condition, the next state SHALL be WB if dirty is 1 and RD otherwise; without that condition the FSM SHALL stay in IDLE.
REQ-005 WB SHALL last exactly 4 cycles, driven by a 2-bit word counter k=0..3, with mem_we=1, mem_addr=victim base+4k, and mem_din=victim_line word k latched at IDLE exit; after k=3 the next state SHALL be RD.
REQ-006 RD SHALL issue reads for 4 cycles (mem_rden=1, mem_addr=line base+4k, k=0..3), then spend one further cycle capturing the last word; RD therefore lasts 5 cycles.
REQ-007 In RD, mem_dout SHALL be captured into refill_line word k-1 on cycle k, for k=1..4.
REQ-008 FILL SHALL last 1 cycle with refill_valid=1, and the next state SHALL be IDLE.
REQ-009 stall SHALL equal (state!=IDLE) OR (state==IDLE AND miss AND (req_rd OR req_wr)), combinationally.
REQ-010 With the miss detected at cycle 0 in IDLE, stall SHALL be high for 7 cycles on a clean miss and 11 cycles on a dirty miss, falling in the first IDLE cycle in which miss=0.
REQ-011 req_rd, req_wr, req_addr, miss, dirty, victim_addr and victim_line SHALL be ignored outside IDLE.
REQ-012 req_rd and req_wr both high SHALL be treated as one miss request.
REQ-013 In IDLE, the block SHALL drive mem_rden=0 and mem_we=0; the pipeline owns hit accesses.
REQ-014 The word counter SHALL wrap 3->0 only at a state exit and SHALL be 0 on entry to WB and to RD.
REQ-015 Address arithmetic SHALL be 32-bit, with no carry out of bit 3 into the tag.
REQ-016 If miss is still 1 in the IDLE cycle after FILL, a new refill SHALL start; there SHALL be no lockout cycle.

Reset
REQ-017 Asserting RESET_N=0 SHALL, asynchronously:
- force state=IDLE and counter=0;
- clear refill_line, both latched bases, mem_addr and mem_din to 0;
- clear mem_rden, mem_we and refill_valid to 0;
- make stall follow REQ-009.
REQ-018 Reset asserted mid-WB or mid-RD SHALL abandon the transfer with no refill_valid pulse; words already written to memory stay written.

Structure
REQ-019 Package otter_cache_pkg SHALL hold the state enum (IDLE, WB, RD, FILL), LINE_WORDS=4, WORD_IDX_W=2 and MEM_SIZE_WORD=2'b10.
REQ-020 One sub-module, line_assembler, SHALL hold refill_line, with a word-index write port and a clear.

Verification
REQ-021 Clean load miss at req_addr=0x0000_1238, with memory words 0x1230..0x123C = A,B,C,D:
- mem_rden high 4 cycles at 0x1230, 0x1234, 0x1238, 0x123C;
- refill_valid pulses once with refill_line={A,B,C,D};
- stall high for exactly 7 cycles.
REQ-022 Dirty store miss with victim_addr=0x0000_2004 and victim_line={W0,W1,W2,W3}:
- mem_we writes W0..W3 to 0x2000..0x200C in order;
- reads from the request line follow;
- stall high for 11 cycles.
REQ-023 Toggle miss and req_addr during RD -> the latched base is unchanged and refill_line is still from the original line.
REQ-024 RESET_N pulled low at WB k=2 -> the next cycle shows state IDLE, all outputs 0, no refill_valid; only 0x2000 and 0x2004 were written.
REQ-025 Back-to-back misses, with miss held 1 into the cycle after FILL -> the second refill starts in that IDLE cycle and stall does not drop between the two refills.
REQ-026 req_rd=req_wr=1 with miss=0 -> stall=0 and no memory port-2 activity from the block.

Source files
------------

// File: rtl/otter_cache_pkg.sv
// Shared types and helpers for the data-cache refill path.
// Line geometry is four 32-bit words, with word0 held in the top bits.
package otter_cache_pkg;

    localparam int unsigned LINE_WORDS    = 4;
    localparam int unsigned WORD_IDX_W    = 2;
    localparam logic [1:0]  MEM_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        FILL = 2'd3
    } refillState_t;

    // Word k of a line sits at [127-32k -: 32].
    function automatic logic [31:0] lineWord(input logic [127:0] line,
                                             input logic [WORD_IDX_W-1:0] idx);
        logic [31:0] w;
        unique case (idx)
            2'd0: w = line[127:96];
            2'd1: w = line[95:64];
            2'd2: w = line[63:32];
            2'd3: w = line[31:0];
            default: w = '0;
        endcase
        return w;
    endfunction

    // The index is spliced in below the tag, so no carry ever reaches bit 4.
    function automatic logic [31:0] wordAddr(input logic [31:0] base,
                                             input logic [WORD_IDX_W-1:0] idx);
        return {base[31:4], idx, 2'b00};
    endfunction

endpackage

// File: rtl/line_assembler.sv
// Holds the refill line being assembled from memory words.
// Supports one indexed word write per cycle and a synchronous clear.
module line_assembler
    import otter_cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  RESET_N,
    input  logic                  clr,
    input  logic                  wrEn,
    input  logic [WORD_IDX_W-1:0] wrIdx,
    input  logic [31:0]           wrData,
    output logic [127:0]          line
);

    logic [127:0] lineQ;

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            lineQ <= '0;
        end else if (clr) begin
            lineQ <= '0;
        end else if (wrEn) begin
            unique case (wrIdx)
                2'd0: lineQ[127:96] <= wrData;
                2'd1: lineQ[95:64]  <= wrData;
                2'd2: lineQ[63:32]  <= wrData;
                2'd3: lineQ[31:0]   <= wrData;
                default: ;
            endcase
        end
    end

    assign line = lineQ;

endmodule

// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss handler: optional dirty-victim writeback, four-word line read,
// then a one-cycle fill strobe; stalls the pipeline for the whole sequence.
module dcache_refill_ctrl
    import otter_cache_pkg::*;
(
    input  logic         clk,
    input  logic         RESET_N,
    input  logic         req_rd,
    input  logic         req_wr,
    input  logic [31:0]  req_addr,
    input  logic         miss,
    input  logic         dirty,
    input  logic [31:0]  victim_addr,
    input  logic [127:0] victim_line,
    input  logic [31:0]  mem_dout,
    output logic [31:0]  mem_addr,
    output logic         mem_rden,
    output logic         mem_we,
    output logic [31:0]  mem_din,
    output logic [1:0]   mem_size,
    output logic         mem_sign,
    output logic [127:0] refill_line,
    output logic         refill_valid,
    output logic         stall
);

    refillState_t          stateQ, stateD;
    logic [WORD_IDX_W-1:0] cntQ, cntD;
    logic                  rdTailQ, rdTailD;
    logic [31:0]           lineBaseQ, victimBaseQ;
    logic [127:0]          victimLineQ;
    logic                  missReq;
    logic                  startRefill;
    logic                  capEn;
    logic [WORD_IDX_W-1:0] capIdx;

    assign missReq     = miss & (req_rd | req_wr);
    assign startRefill = (stateQ == IDLE) & missReq;

    always_comb begin
        stateD  = stateQ;
        cntD    = cntQ;
        rdTailD = rdTailQ;
        unique case (stateQ)
            IDLE: begin
                if (missReq) begin
                    stateD  = dirty ? WB : RD;
                    cntD    = '0;
                    rdTailD = 1'b0;
                end
            end
            WB: begin
                if (cntQ == 2'd3) begin
                    stateD = RD;
                    cntD   = '0;
                end else begin
                    cntD = cntQ + 2'd1;
                end
            end
            RD: begin
                // Counter parks at 3 for the extra cycle that collects the last word.
                if (rdTailQ) begin
                    stateD  = FILL;
                    cntD    = '0;
                    rdTailD = 1'b0;
                end else if (cntQ == 2'd3) begin
                    rdTailD = 1'b1;
                end else begin
                    cntD = cntQ + 2'd1;
                end
            end
            FILL: begin
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            stateQ  <= IDLE;
            cntQ    <= '0;
            rdTailQ <= 1'b0;
        end else begin
            stateQ  <= stateD;
            cntQ    <= cntD;
            rdTailQ <= rdTailD;
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            lineBaseQ   <= '0;
            victimBaseQ <= '0;
            victimLineQ <= '0;
        end else if (startRefill) begin
            lineBaseQ   <= {req_addr[31:4], 4'h0};
            victimBaseQ <= {victim_addr[31:4], 4'h0};
            victimLineQ <= victim_line;
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        mem_rden = 1'b0;
        unique case (stateQ)
            WB: begin
                mem_we   = 1'b1;
                mem_addr = wordAddr(victimBaseQ, cntQ);
                mem_din  = lineWord(victimLineQ, cntQ);
            end
            RD: begin
                if (!rdTailQ) begin
                    mem_rden = 1'b1;
                    mem_addr = wordAddr(lineBaseQ, cntQ);
                end
            end
            default: ;
        endcase
    end

    // Read data trails its address by one cycle, so word k-1 lands on read cycle k.
    assign capEn  = (stateQ == RD) & (rdTailQ | (cntQ != 2'd0));
    assign capIdx = rdTailQ ? 2'd3 : cntQ - 2'd1;

    line_assembler u_lineAsm (
        .clk     (clk),
        .RESET_N (RESET_N),
        .clr     (startRefill),
        .wrEn    (capEn),
        .wrIdx   (capIdx),
        .wrData  (mem_dout),
        .line    (refill_line)
    );

    assign refill_valid = (stateQ == FILL);
    assign stall        = (stateQ != IDLE) | missReq;
    assign mem_size     = MEM_SIZE_WORD;
    assign mem_sign     = 1'b0;

endmodule
